// File: rtl/ins_loader.sv
// ins_loader: boot-time instruction-memory writer.
// Takes a byte stream (header N, then N three-byte words, MSB first),
// writes each assembled word at consecutive fetch addresses, and holds
// the CPU in stall until the image is complete.
// Optional feature macro: INS_LOADER_CHECKSUM_EN adds a trailing XOR
// checksum byte over the 3N payload bytes.
module ins_loader #(
  parameter int INS_W     = 21,
  parameter int ADDR_W    = 8,
  parameter int ADDR_STEP = 4,
  parameter int MAX_WORDS = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              ins_we,
  output logic [ADDR_W-1:0] ins_waddr,
  output logic [INS_W-1:0]  ins_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              err,
  output logic [6:0]        word_count
);

  // Width of the field carried by the first byte of a word.
  localparam int HI_W = INS_W - 16;
  localparam logic [8:0] MAX_W9 = 9'(MAX_WORDS);
  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(ADDR_STEP);

  typedef enum logic [3:0] {
    S_IDLE,
    S_HDR,
    S_B0,
    S_B1,
    S_B2,
    S_WRITE,
`ifdef INS_LOADER_CHECKSUM_EN
    S_CSUM,
`endif
    S_DONE,
    S_ERR
  } state_t;

  state_t            state_reg, state_next;
  logic [7:0]        n_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [ADDR_W-1:0] waddr_reg;
  logic [INS_W-1:0]  wdata_reg;
  logic [HI_W-1:0]   hi_reg;
  logic [7:0]        mid_reg;
  logic [6:0]        count_reg;
  logic [6:0]        count_inc;
  logic              accept;
  logic              load_start;
  logic              hdr_bad;
  logic              last_word;

  assign accept     = byte_valid && byte_ready;
  assign load_start = start && (state_reg == S_IDLE || state_reg == S_DONE || state_reg == S_ERR);
  assign hdr_bad    = (byte_in == 8'd0) || ({1'b0, byte_in} > MAX_W9);
  assign count_inc  = count_reg + 7'd1;
  assign last_word  = ({1'b0, count_inc} == n_reg);

`ifdef INS_LOADER_CHECKSUM_EN
  logic [7:0] csum_reg;

  // Running XOR of payload bytes; the header is not included.
  always_ff @(posedge clk) begin
    if (rst || load_start) begin
      csum_reg <= 8'd0;
    end else if (accept && (state_reg == S_B0 || state_reg == S_B1 || state_reg == S_B2)) begin
      csum_reg <= csum_reg ^ byte_in;
    end
  end
`endif

  // Next-state logic and stream back-pressure.
  always_comb begin
    state_next = state_reg;
    byte_ready = 1'b0;
    case (state_reg)
      S_IDLE: if (start) state_next = S_HDR;
      S_HDR: begin
        byte_ready = 1'b1;
        if (byte_valid) state_next = hdr_bad ? S_ERR : S_B0;
      end
      S_B0: begin
        byte_ready = 1'b1;
        // Unused upper bits must be zero; the bad byte is still consumed.
        if (byte_valid) state_next = (byte_in[7:HI_W] != '0) ? S_ERR : S_B1;
      end
      S_B1: begin
        byte_ready = 1'b1;
        if (byte_valid) state_next = S_B2;
      end
      S_B2: begin
        byte_ready = 1'b1;
        if (byte_valid) state_next = S_WRITE;
      end
      S_WRITE: begin
`ifdef INS_LOADER_CHECKSUM_EN
        state_next = last_word ? S_CSUM : S_B0;
`else
        state_next = last_word ? S_DONE : S_B0;
`endif
      end
`ifdef INS_LOADER_CHECKSUM_EN
      S_CSUM: begin
        byte_ready = 1'b1;
        if (byte_valid) state_next = (byte_in == csum_reg) ? S_DONE : S_ERR;
      end
`endif
      S_DONE:  if (start) state_next = S_HDR;
      S_ERR:   if (start) state_next = S_HDR;
      default: state_next = S_IDLE;
    endcase
  end

  // State, word assembly, write address and count.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_IDLE;
      n_reg     <= 8'd0;
      addr_reg  <= '0;
      waddr_reg <= '0;
      wdata_reg <= '0;
      hi_reg    <= '0;
      mid_reg   <= 8'd0;
      count_reg <= 7'd0;
    end else begin
      state_reg <= state_next;
      if (load_start) begin
        addr_reg  <= '0;
        waddr_reg <= '0;
        count_reg <= 7'd0;
      end
      if (accept) begin
        case (state_reg)
          S_HDR: n_reg   <= byte_in;
          S_B0:  hi_reg  <= byte_in[HI_W-1:0];
          S_B1:  mid_reg <= byte_in;
          S_B2: begin
            // Output registers load together so they stay put between writes.
            wdata_reg <= {hi_reg, mid_reg, byte_in};
            waddr_reg <= addr_reg;
          end
          default: ;
        endcase
      end
      if (state_reg == S_WRITE) begin
        addr_reg  <= addr_reg + STEP;
        count_reg <= count_inc;
      end
    end
  end

  assign ins_we     = (state_reg == S_WRITE);
  assign ins_waddr  = waddr_reg;
  assign ins_wdata  = wdata_reg;
  assign cpu_hold   = !(state_reg == S_IDLE || state_reg == S_DONE);
  assign done       = (state_reg == S_DONE);
  assign err        = (state_reg == S_ERR);
  assign word_count = count_reg;

endmodule

// File: tb/tb_ins_loader.sv
// Scoreboard bench for ins_loader: expected writes are queued as stimulus
// is driven and compared whenever the loader strobes ins_we.
module tb_ins_loader;

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic        ins_we;
  logic [7:0]  ins_waddr;
  logic [20:0] ins_wdata;
  logic        cpu_hold;
  logic        done;
  logic        err;
  logic [6:0]  word_count;

  int n_chk  = 0;
  int n_fail = 0;
  logic [28:0] exp_q[$];
  logic [28:0] mon_e;
  logic [7:0]  csum_acc;

  ins_loader dut (
    .clk(clk), .rst(rst), .start(start), .byte_in(byte_in),
    .byte_valid(byte_valid), .byte_ready(byte_ready), .ins_we(ins_we),
    .ins_waddr(ins_waddr), .ins_wdata(ins_wdata), .cpu_hold(cpu_hold),
    .done(done), .err(err), .word_count(word_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Write monitor: each strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (ins_we === 1'b1) begin
      chk("ready_in_write", {31'd0, byte_ready}, 32'd0);
      if (exp_q.size() == 0) begin
        chk("unexpected_we", 32'd1, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("waddr", {24'd0, ins_waddr}, {24'd0, mon_e[28:21]});
        chk("wdata", {11'd0, ins_wdata}, {11'd0, mon_e[20:0]});
      end
      $display("write addr=0x%02h data=0x%06h", ins_waddr, ins_wdata);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    csum_acc = 8'd0;
    chk("ready_after_start", {31'd0, byte_ready}, 32'd1);
  endtask

  // Offer one byte; optional idle gap before it, optionally poking start.
  task automatic send_byte(input logic [7:0] b, input int gap, input bit poke);
    bit ok;
    ok = 1'b0;
    for (int g = 0; g < gap; g++) begin
      start = poke;
      tick();
      start = 1'b0;
    end
    byte_in    = b;
    byte_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (byte_ready) begin
        tick();
        ok = 1'b1;
        break;
      end
    end
    byte_valid = 1'b0;
    if (!ok) chk("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic send_word(input logic [20:0] d, input logic [7:0] addr,
                           input int gap, input bit poke);
    logic [7:0] b0, b1, b2;
    b0 = {3'b000, d[20:16]};
    b1 = d[15:8];
    b2 = d[7:0];
    exp_q.push_back({addr, d});
    csum_acc = csum_acc ^ b0 ^ b1 ^ b2;
    send_byte(b0, gap, poke);
    send_byte(b1, gap, poke);
    send_byte(b2, gap, poke);
  endtask

  task automatic finish_image(input bit good);
`ifdef INS_LOADER_CHECKSUM_EN
    send_byte(good ? csum_acc : (csum_acc ^ 8'hFF), 0, 1'b0);
`else
    if (!good) $display("checksum disabled, bad-checksum case skipped");
`endif
  endtask

  task automatic wait_end();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (done || err) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("end_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    logic [20:0] d;
    rst = 1'b1; start = 1'b0; byte_in = 8'd0; byte_valid = 1'b0; csum_acc = 8'd0;
    repeat (3) tick();
    rst = 1'b0;
    chk("rst_we", {31'd0, ins_we}, 32'd0);
    chk("rst_ready", {31'd0, byte_ready}, 32'd0);
    chk("rst_hold", {31'd0, cpu_hold}, 32'd0);
    chk("rst_done_err", {30'd0, done, err}, 32'd0);
    chk("rst_count", {25'd0, word_count}, 32'd0);
    chk("rst_waddr", {24'd0, ins_waddr}, 32'd0);

    // Two-word image, good checksum.
    do_start();
    chk("hold_loading", {31'd0, cpu_hold}, 32'd1);
    send_byte(8'h02, 0, 1'b0);
    send_word(21'h1FABCD, 8'h00, 0, 1'b0);
    send_word(21'h000001, 8'h04, 0, 1'b0);
    finish_image(1'b1);
    wait_end();
    chk("a_done", {31'd0, done}, 32'd1);
    chk("a_err", {31'd0, err}, 32'd0);
    chk("a_hold", {31'd0, cpu_hold}, 32'd0);
    chk("a_count", {25'd0, word_count}, 32'd2);
    $display("image A: done=%0b err=%0b count=%0d", done, err, word_count);

`ifdef INS_LOADER_CHECKSUM_EN
    // Same image, wrong checksum: words still land, load ends in error.
    do_start();
    send_byte(8'h02, 0, 1'b0);
    send_word(21'h1FABCD, 8'h00, 0, 1'b0);
    send_word(21'h000001, 8'h04, 0, 1'b0);
    finish_image(1'b0);
    wait_end();
    chk("csum_err", {31'd0, err}, 32'd1);
    chk("csum_hold", {31'd0, cpu_hold}, 32'd1);
    chk("csum_done", {31'd0, done}, 32'd0);
    $display("bad checksum: err=%0b hold=%0b", err, cpu_hold);
`endif

    // Header out of range at both ends.
    do_start();
    send_byte(8'h00, 0, 1'b0);
    chk("hdr0_err", {31'd0, err}, 32'd1);
    chk("hdr0_ready", {31'd0, byte_ready}, 32'd0);
    $display("header 0x00: err=%0b", err);
    do_start();
    send_byte(8'h41, 0, 1'b0);
    chk("hdr41_err", {31'd0, err}, 32'd1);
    chk("hdr41_hold", {31'd0, cpu_hold}, 32'd1);
    $display("header 0x41: err=%0b", err);

    // Bad first word byte, then a clean restart at address 0.
    do_start();
    send_byte(8'h01, 0, 1'b0);
    send_byte(8'h20, 0, 1'b0);
    chk("b0_err", {31'd0, err}, 32'd1);
    $display("first byte 0x20: err=%0b", err);
    do_start();
    chk("restart_count", {25'd0, word_count}, 32'd0);
    send_byte(8'h01, 0, 1'b0);
    send_word(21'h012345, 8'h00, 0, 1'b0);
    finish_image(1'b1);
    wait_end();
    chk("restart_done", {31'd0, done}, 32'd1);
    $display("restart: done=%0b", done);

    // Gapped stream with start poked mid-load, then reset after word 2.
    do_start();
    send_byte(8'h03, 1, 1'b1);
    send_word(21'h0A0B0C, 8'h00, 1, 1'b1);
    send_word(21'h15A5F0, 8'h04, 1, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_outs", {24'd0, ins_we, byte_ready, cpu_hold, done, err, 3'd0}, 32'd0);
    chk("mid_rst_count", {25'd0, word_count}, 32'd0);
    chk("mid_rst_waddr", {24'd0, ins_waddr}, 32'd0);
    chk("mid_rst_wdata", {11'd0, ins_wdata}, 32'd0);
    $display("mid-load reset: hold=%0b count=%0d", cpu_hold, word_count);

    // Largest image: last write lands at 0xFC.
    do_start();
    send_byte(8'd64, 0, 1'b0);
    for (int i = 0; i < 64; i++) begin
      d = 21'($urandom_range(0, 21'h1FFFFF));
      send_word(d, 8'(i * 4), 0, 1'b0);
    end
    finish_image(1'b1);
    wait_end();
    chk("max_done", {31'd0, done}, 32'd1);
    chk("max_count", {25'd0, word_count}, 32'd64);
    chk("max_last_addr", {24'd0, ins_waddr}, 32'h0FC);
    $display("max image: done=%0b count=%0d last_addr=0x%02h", done, word_count, ins_waddr);

    repeat (3) tick();
    chk("queue_empty", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
